// File: rtl/id_hazard_ctrl_if.sv
// Decode-stage hazard control bundle: ID/EX/MEM status in, pipeline-register control out.
// HAZ_PERF_EN adds the hazard-stall and taken-branch performance counters.
interface id_hazard_ctrl_if;
  logic       i_id_valid;
  logic [4:0] i_rs1;
  logic       i_rs1_en;
  logic [4:0] i_rs2;
  logic       i_rs2_en;
  logic [4:0] i_rd;
  logic       i_rd_we;
  logic       i_is_load;
  logic       i_br_taken;
  logic       i_mem_busy;
  logic       o_stall_pc;
  logic       o_stall_ifid;
  logic       o_bubble_idex;
  logic       o_flush_ifid;
  logic       o_issue;
  logic [1:0] o_state;
`ifdef HAZ_PERF_EN
  logic [31:0] o_perf_stall;
  logic [31:0] o_perf_flush;
`endif

  modport master (
`ifdef HAZ_PERF_EN
    input  o_perf_stall, o_perf_flush,
`endif
    output i_id_valid, i_rs1, i_rs1_en, i_rs2, i_rs2_en, i_rd, i_rd_we,
           i_is_load, i_br_taken, i_mem_busy,
    input  o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_issue, o_state
  );

  modport slave (
`ifdef HAZ_PERF_EN
    output o_perf_stall, o_perf_flush,
`endif
    input  i_id_valid, i_rs1, i_rs1_en, i_rs2, i_rs2_en, i_rd, i_rd_we,
           i_is_load, i_br_taken, i_mem_busy,
    output o_stall_pc, o_stall_ifid, o_bubble_idex, o_flush_ifid, o_issue, o_state
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: load scoreboard plus RUN/FLUSH/HOLD sequencing.
// Optional macro HAZ_PERF_EN adds saturating stall/flush performance counters.
module id_hazard_ctrl #(
  parameter int unsigned NREG      = 32,
  parameter int unsigned LOAD_LAT  = 2,
  parameter int unsigned FLUSH_CYC = 1
) (
  input logic            i_clk,
  input logic            i_rst_n,
  id_hazard_ctrl_if.slave bus
);
  localparam int unsigned CNT_W = 3;
  localparam int unsigned FC_W  = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  logic [FC_W-1:0]  r_flushcnt;
  logic [CNT_W-1:0] r_cnt [NREG];

  logic             w_rs1_pend;
  logic             w_rs2_pend;
  logic             w_hazard;
  logic             w_in_flush;
  logic             w_freeze;
  logic             w_record;
  logic [CNT_W-1:0] w_rd_val;
  logic             w_stall_pc;
  logic             w_stall_ifid;
  logic             w_bubble_idex;
  logic             w_flush_ifid;
  logic             w_issue;

  assign w_rs1_pend = bus.i_rs1_en && (bus.i_rs1 != '0) && (32'(bus.i_rs1) < NREG)
                      && (r_cnt[bus.i_rs1] != '0);
  assign w_rs2_pend = bus.i_rs2_en && (bus.i_rs2 != '0) && (32'(bus.i_rs2) < NREG)
                      && (r_cnt[bus.i_rs2] != '0);
  assign w_hazard   = bus.i_id_valid && (w_rs1_pend || w_rs2_pend);
  // A HOLD entered from FLUSH keeps squashing once MEM releases.
  assign w_in_flush = (r_state == ST_FLUSH) || ((r_state == ST_HOLD) && (r_flushcnt != '0));
  assign w_freeze   = bus.i_mem_busy && !bus.i_br_taken;
  assign w_record   = w_issue && bus.i_rd_we && (bus.i_rd != '0) && (32'(bus.i_rd) < NREG);
  assign w_rd_val   = bus.i_is_load ? CNT_W'(LOAD_LAT) : '0;

  // Priority: branch > mem busy > flush > hazard > issue; all zero in reset.
  always_comb begin
    w_stall_pc    = 1'b0;
    w_stall_ifid  = 1'b0;
    w_bubble_idex = 1'b0;
    w_flush_ifid  = 1'b0;
    w_issue       = 1'b0;
    if (!i_rst_n) begin
      w_issue = 1'b0;
    end else if (bus.i_br_taken) begin
      w_flush_ifid  = 1'b1;
      w_bubble_idex = 1'b1;
    end else if (bus.i_mem_busy) begin
      w_stall_pc   = 1'b1;
      w_stall_ifid = 1'b1;
    end else if (w_in_flush) begin
      w_flush_ifid  = 1'b1;
      w_bubble_idex = 1'b1;
    end else if (w_hazard) begin
      w_stall_pc    = 1'b1;
      w_stall_ifid  = 1'b1;
      w_bubble_idex = 1'b1;
    end else begin
      w_issue = bus.i_id_valid;
    end
  end

  assign bus.o_stall_pc    = w_stall_pc;
  assign bus.o_stall_ifid  = w_stall_ifid;
  assign bus.o_bubble_idex = w_bubble_idex;
  assign bus.o_flush_ifid  = w_flush_ifid;
  assign bus.o_issue       = w_issue;
  assign bus.o_state       = r_state;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_RUN;
      r_flushcnt <= '0;
      for (int unsigned r = 0; r < NREG; r++) r_cnt[r] <= '0;
    end else begin
      // Issue write wins over aging for the same register.
      for (int unsigned r = 1; r < NREG; r++) begin
        if (w_record && (32'(bus.i_rd) == r)) begin
          r_cnt[r] <= w_rd_val;
        end else if (!w_freeze && (r_cnt[r] != '0)) begin
          r_cnt[r] <= r_cnt[r] - CNT_W'(1);
        end
      end
      if (bus.i_br_taken) begin
        r_flushcnt <= FC_W'(FLUSH_CYC);
        r_state    <= (FLUSH_CYC != 0) ? ST_FLUSH : ST_RUN;
      end else if (bus.i_mem_busy) begin
        r_state <= ST_HOLD;
      end else if (w_in_flush) begin
        if (r_flushcnt <= FC_W'(1)) begin
          r_flushcnt <= '0;
          r_state    <= ST_RUN;
        end else begin
          r_flushcnt <= r_flushcnt - FC_W'(1);
          r_state    <= ST_FLUSH;
        end
      end else begin
        r_state <= ST_RUN;
      end
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_flush;
  logic        w_haz_stall;

  assign w_haz_stall = w_hazard && !bus.i_br_taken && !bus.i_mem_busy && !w_in_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if (w_haz_stall && (r_perf_stall != '1)) r_perf_stall <= r_perf_stall + 32'd1;
      if (bus.i_br_taken && (r_perf_flush != '1)) r_perf_flush <= r_perf_flush + 32'd1;
    end
  end

  assign bus.o_perf_stall = r_perf_stall;
  assign bus.o_perf_flush = r_perf_flush;
`endif
endmodule

// File: doc/id_hazard_ctrl.md
Name: id_hazard_ctrl

Overview:
- Pipeline hazard controller for the decode (ID) stage of the RV32I core.
- Keeps a per-register load scoreboard and decides, every cycle, whether the instruction in ID issues to EX, stalls with a bubble, or is flushed.
- Drives the PC, IF/ID and ID/EX pipeline-register control. Consumes decoded register fields from ID, branch resolution from EX and the busy flag from MEM.

Parameters:
- NREG, 32, number of architectural registers; x0 is never tracked.
- LOAD_LAT, 2, cycles after load issue until its data is forwardable to ID; range 1..7.
- FLUSH_CYC, 1, extra cycles ID stays squashed after a taken branch; range 0..3.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_id_valid  in  1  valid instruction present in ID
- i_rs1  in  5  source register 1 index
- i_rs1_en  in  1  instruction reads rs1
- i_rs2  in  5  source register 2 index
- i_rs2_en  in  1  instruction reads rs2
- i_rd  in  5  destination register index
- i_rd_we  in  1  instruction writes rd
- i_is_load  in  1  instruction is a LOAD
- i_br_taken  in  1  EX resolved taken branch/jump this cycle
- i_mem_busy  in  1  MEM stage cannot accept; freeze whole pipe
- o_stall_pc  out  1  hold PC
- o_stall_ifid  out  1  hold IF/ID register
- o_bubble_idex  out  1  load NOP into ID/EX
- o_flush_ifid  out  1  invalidate IF/ID contents
- o_issue  out  1  ID instruction advances to EX this cycle
- o_state  out  2  FSM state: 0 RUN, 1 FLUSH, 2 HOLD

Behaviour:
- One clock domain, i_clk. Reset is asynchronous and active-low on i_rst_n; release is synchronous to i_clk.
- Reset state: FSM=RUN, all scoreboard counters 0, flush counter 0.
- Reset values of outputs: all outputs 0 while in reset (state RUN, o_state=0).
- FSM state and scoreboard are registered. All control outputs are combinational from the registered state plus the current inputs, so they have zero latency.
- Scoreboard:
  - cnt[r] is 3 bits, one per r in 1..NREG-1.
  - Hazard = i_id_valid & ((i_rs1_en & i_rs1!=0 & cnt[i_rs1]!=0) | (i_rs2_en & i_rs2!=0 & cnt[i_rs2]!=0)).
  - On o_issue with i_rd_we and i_rd!=0: cnt[i_rd] <= LOAD_LAT if i_is_load, else 0. A newer ALU write supersedes an older pending load (WAW).
  - Every cycle that is not frozen, each nonzero cnt decrements by 1. The issue write takes priority over the decrement for the same index.
  - Freeze = i_mem_busy. During a freeze, counters hold.
- Priority each cycle: i_br_taken > i_mem_busy > FLUSH state > hazard > issue.
- Taken branch (any state):
  - o_flush_ifid=1, o_bubble_idex=1, o_issue=0, PC not stalled.
  - Go to FLUSH with flushcnt=FLUSH_CYC if FLUSH_CYC>0, else stay in RUN.
  - Scoreboard still decrements. The squashed instruction is not recorded.
- FLUSH state:
  - o_flush_ifid=1, o_bubble_idex=1, o_issue=0.
  - flushcnt decrements each cycle; at 1, return to RUN.
  - A new i_br_taken reloads flushcnt.
- HOLD (i_mem_busy=1, no branch):
  - o_stall_pc=o_stall_ifid=1, o_bubble_idex=0, o_issue=0.
  - Enter/remain in HOLD while busy. When busy drops, return to RUN, or to FLUSH if flushcnt!=0 was saved.
- RUN with hazard: o_stall_pc=o_stall_ifid=o_bubble_idex=1, o_issue=0.
- RUN with no hazard: o_issue=i_id_valid, all other control outputs 0.
- i_id_valid=0: no issue, no hazard, and the scoreboard still ages.
- Reset mid-stall or mid-flush: immediate return to RUN with the scoreboard cleared.

Optional Feature:
- Macro: HAZ_PERF_EN.
- When defined, adds outputs o_perf_stall (32, count of hazard-stall cycles) and o_perf_flush (32, count of i_br_taken events). Both are saturating at 32'hFFFFFFFF and reset to 0.
- When undefined, these ports and their counters are absent and behaviour is otherwise identical.

Test Plan:
- LOAD x5 issues, next instruction reads rs1=x5, LOAD_LAT=2 -> 2 cycles of stall_pc/stall_ifid/bubble_idex=1, then o_issue=1 in cycle 3.
- LOAD x0, then a read of x0 -> no stall, o_issue=1 back-to-back.
- LOAD x7, then ADD x7 issues (WAW; dependent on a different register), then a read of x7 -> no stall, since cnt[7] was cleared by the ADD.
- Hazard pending and i_br_taken=1 in the same cycle -> flush_ifid=1, bubble_idex=1, stall_pc=0; FLUSH for 1 cycle, then RUN.
- LOAD x3, then i_mem_busy=1 for 4 cycles with a reader of x3 in ID -> o_state=2, cnt[3] holds at 2; after release, 2 stall cycles, then issue.
- Assert i_rst_n=0 asynchronously during FLUSH -> outputs 0 and o_state=0 with no clock edge; after release, a reader of any register issues immediately.
